// File: rtl/identificador_compuerta.sv
// identificador_compuerta: probes a 3-input selectable gate unit through an
// enable check and all 8 input vectors, captures its truth table and decodes
// it back to the unit's 3-bit sel code.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | probes at 0, results held, waiting for inicio
// PROBE_OFF | act=0, ent=111; sal must stay 0 or act_err is flagged
// SWEEP     | act=1, ent=idx; sal captured into tabla[idx] per vector
// DECODE    | probes at 0; table decoded, results registered
// DONE      | one-cycle valido pulse, back to IDLE

module identificador_compuerta #(
    parameter int SETTLE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inicio,
    input  logic       sal_in,
    output logic       ent1_o,
    output logic       ent2_o,
    output logic       ent3_o,
    output logic       act_o,
    output logic       ocupado,
    output logic       valido,
    output logic [2:0] sel_det,
    output logic [7:0] tabla,
    output logic       error
);

    // One extra bit keeps the counter at least 1 bit wide when SETTLE = 0.
    localparam int CW = $clog2(SETTLE + 2);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PROBE_OFF = 3'd1,
        SWEEP     = 3'd2,
        DECODE    = 3'd3,
        DONE      = 3'd4
    } estado_t;

    estado_t       estado;
    estado_t       estado_sig;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    tabla_int;
    logic          act_err;
    logic          tc;
    logic [2:0]    sel_dec;
    logic          err_dec;

    // Settle hold ends when the down-counter reaches zero.
    assign tc = (cnt == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next state and probe/status outputs, decoded from the current state.
    always_comb begin
        estado_sig = estado;
        ent1_o     = 1'b0;
        ent2_o     = 1'b0;
        ent3_o     = 1'b0;
        act_o      = 1'b0;
        ocupado    = 1'b0;
        valido     = 1'b0;
        case (estado)
            IDLE: begin
                if (inicio) begin
                    estado_sig = PROBE_OFF;
                end
            end
            PROBE_OFF: begin
                ocupado = 1'b1;
                {ent1_o, ent2_o, ent3_o} = 3'b111;
                if (tc) begin
                    estado_sig = SWEEP;
                end
            end
            SWEEP: begin
                ocupado = 1'b1;
                act_o   = 1'b1;
                {ent1_o, ent2_o, ent3_o} = idx;
                if (tc && (idx == 3'd7)) begin
                    estado_sig = DECODE;
                end
            end
            DECODE: begin
                ocupado    = 1'b1;
                estado_sig = DONE;
            end
            DONE: begin
                valido     = 1'b1;
                estado_sig = IDLE;
            end
            default: begin
                estado_sig = IDLE;
            end
        endcase
    end

    // Table decode; an enable-check failure overrides whatever was captured.
    always_comb begin
        sel_dec = 3'b000;
        err_dec = 1'b0;
        if (act_err) begin
            err_dec = 1'b1;
        end else begin
            case (tabla_int)
                8'h80:   sel_dec = 3'b001;
                8'hFE:   sel_dec = 3'b010;
                8'h96:   sel_dec = 3'b011;
                8'h7F:   sel_dec = 3'b100;
                8'h01:   sel_dec = 3'b101;
                8'h69:   sel_dec = 3'b110;
                8'h00:   sel_dec = 3'b000;
                default: err_dec = 1'b1;
            endcase
        end
    end

    // Settle counter, vector index, capture registers and held results.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= 3'd0;
            tabla_int <= 8'h00;
            act_err   <= 1'b0;
            sel_det   <= 3'b000;
            tabla     <= 8'h00;
            error     <= 1'b0;
        end else begin
            case (estado)
                IDLE: begin
                    if (inicio) begin
                        cnt       <= CNT_LOAD;
                        idx       <= 3'd0;
                        tabla_int <= 8'h00;
                        act_err   <= 1'b0;
                    end
                end
                PROBE_OFF: begin
                    if (tc) begin
                        act_err <= sal_in;
                        cnt     <= CNT_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SWEEP: begin
                    if (tc) begin
                        tabla_int[idx] <= sal_in;
                        cnt            <= CNT_LOAD;
                        if (idx != 3'd7) begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DECODE: begin
                    sel_det <= sel_dec;
                    error   <= err_dec;
                    tabla   <= tabla_int;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_identificador_compuerta.sv
// Bench for identificador_compuerta: one instance with SETTLE=0 driving a
// combinational gate model, one with SETTLE=2 driving a 2-stage registered one.

module tb_identificador_compuerta;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       inicio0 = 1'b0;
    logic       sal0;
    logic       e1_0, e2_0, e3_0, act0, ocupado0, valido0, error0;
    logic [2:0] sel_det0;
    logic [7:0] tabla0;

    logic       inicio2 = 1'b0;
    logic       sal2;
    logic       e1_2, e2_2, e3_2, act2, ocupado2, valido2, error2;
    logic [2:0] sel_det2;
    logic [7:0] tabla2;

    // Gate model controls: mode 0 = real gate, 1 = sal forced, 2 = arbitrary table
    int         mode0 = 0;
    logic [2:0] sel0  = 3'b000;
    logic       fv0   = 1'b0;
    logic [7:0] rt0   = 8'h00;
    logic [2:0] sel2  = 3'b001;
    logic       r1, r2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    identificador_compuerta #(.SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .inicio(inicio0), .sal_in(sal0),
        .ent1_o(e1_0), .ent2_o(e2_0), .ent3_o(e3_0), .act_o(act0),
        .ocupado(ocupado0), .valido(valido0), .sel_det(sel_det0),
        .tabla(tabla0), .error(error0)
    );

    identificador_compuerta #(.SETTLE(2)) dut2 (
        .clk(clk), .rst(rst), .inicio(inicio2), .sal_in(sal2),
        .ent1_o(e1_2), .ent2_o(e2_2), .ent3_o(e3_2), .act_o(act2),
        .ocupado(ocupado2), .valido(valido2), .sel_det(sel_det2),
        .tabla(tabla2), .error(error2)
    );

    function automatic logic gate_out(input logic [2:0] s, input logic act,
                                      input logic a, input logic b, input logic c);
        if (!act) return 1'b0;
        case (s)
            3'd1:    return a & b & c;
            3'd2:    return a | b | c;
            3'd3:    return a ^ b ^ c;
            3'd4:    return ~(a & b & c);
            3'd5:    return ~(a | b | c);
            3'd6:    return ~(a ^ b ^ c);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] truth(input logic [2:0] s);
        logic [7:0] t;
        logic [2:0] v;
        t = 8'h00;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            t[i] = gate_out(s, 1'b1, v[2], v[1], v[0]);
        end
        return t;
    endfunction

    // {error, sel}: identify the gate whose truth table matches
    function automatic logic [3:0] ref_decode(input logic [7:0] t, input logic aerr);
        if (aerr) return 4'b1000;
        if (t == 8'h00) return 4'b0000;
        for (int s = 1; s <= 6; s++) begin
            if (truth(3'(s)) == t) return {1'b0, 3'(s)};
        end
        return 4'b1000;
    endfunction

    always_comb begin
        sal0 = 1'b0;
        case (mode0)
            0:       sal0 = gate_out(sel0, act0, e1_0, e2_0, e3_0);
            1:       sal0 = fv0;
            default: sal0 = act0 ? rt0[{e1_0, e2_0, e3_0}] : 1'b0;
        endcase
    end

    // Two-stage registered gate model for the SETTLE=2 instance
    always_ff @(posedge clk) begin
        if (rst) begin
            r1 <= 1'b0;
            r2 <= 1'b0;
        end else begin
            r1 <= gate_out(sel2, act2, e1_2, e2_2, e3_2);
            r2 <= r1;
        end
    end
    assign sal2 = r2;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sweep0(input string tag);
        int         lat;
        logic [7:0] et;
        logic [3:0] ed;
        case (mode0)
            0:       et = truth(sel0);
            1:       et = {8{fv0}};
            default: et = rt0;
        endcase
        ed = ref_decode(et, (mode0 == 1) && fv0);
        inicio0 = 1'b1;
        @(posedge clk); #1;
        inicio0 = 1'b0;
        check_val({tag, "_busy"}, 32'(ocupado0), 32'd1);
        lat = 0;
        while (!valido0 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val({tag, "_lat"}, 32'(lat), 32'd10);
        check_val({tag, "_tabla"}, 32'(tabla0), 32'(et));
        check_val({tag, "_sel"}, 32'(sel_det0), 32'(ed[2:0]));
        check_val({tag, "_err"}, 32'(error0), 32'(ed[3]));
        @(posedge clk); #1;
        check_val({tag, "_pulse"}, 32'({valido0, ocupado0}), 32'd0);
    endtask

    initial begin
        int         lat;
        int         gap;
        int         seen;
        logic [3:0] ed;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out0", 32'({e1_0, e2_0, e3_0, act0, ocupado0, valido0, error0}), 32'd0);
        check_val("rst_res0", 32'({sel_det0, tabla0}), 32'd0);
        check_val("rst_out2", 32'({act2, ocupado2, valido2, sel_det2, tabla2, error2}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        mode0 = 0;
        sel0  = 3'd1;
        sweep0("and");
        for (int s = 2; s <= 7; s++) begin
            sel0 = 3'(s);
            sweep0($sformatf("sel%0d", s));
        end
        sel0 = 3'd0;
        sweep0("sel0");

        mode0 = 1;
        fv0   = 1'b1;
        sweep0("force1");
        fv0   = 1'b0;
        sweep0("force0");

        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                mode0 = 0;
                sel0  = 3'($urandom_range(0, 7));
            end else begin
                mode0 = 2;
                rt0   = 8'($urandom);
            end
            sweep0($sformatf("rnd%0d", k));
        end

        // Abort mid-sweep at vector 4
        mode0 = 0;
        sel0  = 3'd2;
        sweep0("pre_abort");
        sel0    = 3'd1;
        inicio0 = 1'b1;
        @(posedge clk); #1;
        inicio0 = 1'b0;
        lat = 0;
        while (!(act0 && {e1_0, e2_0, e3_0} == 3'd4) && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("abort_reach_idx4", 32'(lat < 50), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("abort_out", 32'({e1_0, e2_0, e3_0, act0, ocupado0, valido0, error0}), 32'd0);
        check_val("abort_res", 32'({sel_det0, tabla0}), 32'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (valido0 || ocupado0) seen++;
        end
        check_val("abort_quiet", 32'(seen), 32'd0);
        sweep0("rerun_and");

        // SETTLE=2, registered gate, inicio held high across two sweeps
        sel2 = 3'($urandom_range(1, 6));
        ed   = ref_decode(truth(sel2), 1'b0);
        inicio2 = 1'b1;
        @(posedge clk); #1;
        check_val("s2_busy", 32'(ocupado2), 32'd1);
        lat = 0;
        gap = 0;
        while (!valido2 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (!valido2 && !ocupado2) gap++;
        end
        check_val("s2_lat", 32'(lat), 32'd28);
        check_val("s2_gap", 32'(gap), 32'd0);
        check_val("s2_tabla", 32'(tabla2), 32'(truth(sel2)));
        check_val("s2_sel", 32'(sel_det2), 32'(ed[2:0]));
        check_val("s2_err", 32'(error2), 32'(ed[3]));
        @(posedge clk); #1;
        check_val("s2_idle", 32'({valido2, ocupado2}), 32'd0);
        @(posedge clk); #1;
        inicio2 = 1'b0;
        check_val("s2_restart", 32'(ocupado2), 32'd1);
        lat = 0;
        while (!valido2 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("s2_lat2", 32'(lat), 32'd28);
        check_val("s2_sel2", 32'(sel_det2), 32'(ed[2:0]));
        @(posedge clk); #1;
        check_val("s2_end", 32'({valido2, ocupado2}), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
